lane_scroller: RTL and testbench

LANE_SCROLLER -- requirements
Module: lane_scroller

---
 rtl/scroll_pkg.sv | 12 +
 rtl/lane_stepper.sv | 65 ++++++
 rtl/lane_scroller.sv | 71 +++++++
 tb/tb_lane_scroller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// Shared defaults for the lane scroller: widths, timing and wrap constants.
package scroll_pkg;

  localparam int          DEF_NUM_LANES     = 4;
  localparam int          DEF_POS_W         = 11;
  localparam int          DEF_SPEED_W       = 24;
  localparam int unsigned DEF_INITIAL_SPEED = 250000;  // 10 ms at 25 MHz
  localparam int unsigned DEF_MIN_SPEED     = 25000;
  localparam int          DEF_POS_LIMIT     = 1280;
  localparam int          DEF_HOLD_MODE     = 1;

endpackage

// File: rtl/lane_stepper.sv
// One scrolling lane: step-period counter, expiry compare and wrapping position.
module lane_stepper
  import scroll_pkg::*;
#(
  parameter int POS_W     = DEF_POS_W,
  parameter int SPEED_W   = DEF_SPEED_W,
  parameter int POS_LIMIT = DEF_POS_LIMIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               dir,
  input  logic [1:0]         shift,
  input  logic [SPEED_W-1:0] speed,
  output logic [POS_W-1:0]   pos,
  output logic               tick
);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(POS_LIMIT - 1);

  logic [SPEED_W-1:0] cnt;
  logic [SPEED_W-1:0] shifted;
  logic [SPEED_W-1:0] period;
  logic [POS_W-1:0]   pos_next;
  logic               expire;

  // Lane period is the base speed scaled down by the lane shift, never below one clock.
  always_comb begin
    shifted = speed >> shift;
    period  = (shifted == '0) ? SPEED_W'(1) : shifted;
    // >= rather than == so a shortened period expires at once instead of overshooting.
    expire  = (cnt >= period - SPEED_W'(1));
  end

  // Next position with wrap in both directions; dir is only looked at when a step happens.
  always_comb begin
    pos_next = pos;
    if (dir == 1'b0) begin
      pos_next = (pos == POS_MAX) ? '0 : pos + POS_W'(1);
    end else begin
      pos_next = (pos == '0) ? POS_MAX : pos - POS_W'(1);
    end
  end

  // Counter, position and tick registers; everything freezes while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      pos  <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      if (expire) begin
        cnt  <= '0;
        pos  <= pos_next;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + SPEED_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/lane_scroller.sv
// Multi-lane scroller: shared base speed with level-up saturation, common enable, N lanes.
module lane_scroller
  import scroll_pkg::*;
#(
  parameter int          NUM_LANES     = DEF_NUM_LANES,
  parameter int          POS_W         = DEF_POS_W,
  parameter int          SPEED_W       = DEF_SPEED_W,
  parameter int unsigned INITIAL_SPEED = DEF_INITIAL_SPEED,
  parameter int unsigned MIN_SPEED     = DEF_MIN_SPEED,
  parameter int          POS_LIMIT     = DEF_POS_LIMIT,
  parameter int          HOLD_MODE     = DEF_HOLD_MODE
) (
  input  logic                       clk,
  input  logic                       sys_rst,
  input  logic                       game_rst,
  input  logic                       halt,
  input  logic                       move_btn,
  input  logic                       level_up,
  input  logic [7:0]                 speed_change,
  input  logic [NUM_LANES-1:0]       lane_dir,
  input  logic [2*NUM_LANES-1:0]     lane_shift,
  output logic [NUM_LANES*POS_W-1:0] pos,
  output logic [SPEED_W-1:0]         speed,
  output logic [NUM_LANES-1:0]       tick
);

  // Extra headroom so speed_change + MIN_SPEED cannot overflow the compare.
  localparam int WIDE = SPEED_W + 9;

  logic            rst_any;
  logic            enable;
  logic [WIDE-1:0] speed_wide;
  logic [WIDE-1:0] floor_wide;
  logic [WIDE-1:0] diff_wide;

  // Either reset source clears the whole game; enable gates every lane together.
  always_comb begin
    rst_any    = sys_rst | game_rst;
    enable     = !halt && ((HOLD_MODE == 0) || move_btn);
    speed_wide = WIDE'(speed);
    floor_wide = WIDE'(speed_change) + WIDE'(MIN_SPEED);
    diff_wide  = speed_wide - WIDE'(speed_change);
  end

  // Base speed register: level-up shortens the period, saturating at MIN_SPEED.
  always_ff @(posedge clk) begin
    if (rst_any) begin
      speed <= SPEED_W'(INITIAL_SPEED);
    end else if (level_up && !halt) begin
      speed <= (speed_wide >= floor_wide) ? diff_wide[SPEED_W-1:0] : SPEED_W'(MIN_SPEED);
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_stepper #(
      .POS_W    (POS_W),
      .SPEED_W  (SPEED_W),
      .POS_LIMIT(POS_LIMIT)
    ) u_lane (
      .clk   (clk),
      .rst   (rst_any),
      .enable(enable),
      .dir   (lane_dir[i]),
      .shift (lane_shift[2*i +: 2]),
      .speed (speed),
      .pos   (pos[i*POS_W +: POS_W]),
      .tick  (tick[i])
    );
  end

endmodule

// File: tb/tb_lane_scroller.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a behavioural model of the scroller.
module tb_lane_scroller;

  localparam int NL      = 2;
  localparam int PW      = 11;
  localparam int SW      = 24;
  localparam int INIT_SP = 8;
  localparam int MIN_SP  = 2;
  localparam int LIMIT   = 10;

  logic             clk = 1'b0;
  logic             sys_rst = 1'b0;
  logic             game_rst = 1'b0;
  logic             halt = 1'b0;
  logic             move_btn = 1'b0;
  logic             level_up = 1'b0;
  logic [7:0]       speed_change = 8'd0;
  logic [NL-1:0]    lane_dir = '0;
  logic [2*NL-1:0]  lane_shift = '0;
  logic [NL*PW-1:0] pos;
  logic [SW-1:0]    speed;
  logic [NL-1:0]    tick;

  int checks = 0;
  int errors = 0;
  int tick0_seen = 0;

  // model state
  int m_pos[NL];
  int m_cnt[NL];
  int m_tick[NL];
  int m_speed;
  bit m_valid = 1'b0;

  lane_scroller #(
    .NUM_LANES(NL), .POS_W(PW), .SPEED_W(SW),
    .INITIAL_SPEED(INIT_SP), .MIN_SPEED(MIN_SP), .POS_LIMIT(LIMIT), .HOLD_MODE(1)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .game_rst(game_rst), .halt(halt),
    .move_btn(move_btn), .level_up(level_up), .speed_change(speed_change),
    .lane_dir(lane_dir), .lane_shift(lane_shift),
    .pos(pos), .speed(speed), .tick(tick)
  );

  always #5 clk = ~clk;

  // Behavioural model: a lane steps once every 'period' enabled cycles, where
  // period = max(1, speed / 2^shift); positions move modulo LIMIT.
  always @(posedge clk) begin
    int per;
    bit en;
    if (sys_rst || game_rst) begin
      for (int i = 0; i < NL; i++) begin
        m_pos[i] = 0; m_cnt[i] = 0; m_tick[i] = 0;
      end
      m_speed = INIT_SP;
      m_valid = 1'b1;
    end else begin
      en = !halt && move_btn;
      for (int i = 0; i < NL; i++) begin
        per = m_speed / (1 << lane_shift[2*i +: 2]);
        if (per < 1) per = 1;
        m_tick[i] = 0;
        if (en) begin
          if (m_cnt[i] + 1 >= per) begin
            m_cnt[i]  = 0;
            m_tick[i] = 1;
            if (lane_dir[i]) m_pos[i] = (m_pos[i] + LIMIT - 1) % LIMIT;
            else             m_pos[i] = (m_pos[i] + 1) % LIMIT;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      if (level_up && !halt) begin
        m_speed = m_speed - int'(speed_change);
        if (m_speed < MIN_SP) m_speed = MIN_SP;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (m_valid) begin
      for (int i = 0; i < NL; i++) begin
        chk($sformatf("model_pos%0d", i), int'(pos[i*PW +: PW]), m_pos[i]);
        chk($sformatf("model_tick%0d", i), int'(tick[i]), m_tick[i]);
      end
      chk("model_speed", int'(speed), m_speed);
    end
  endtask

  task automatic step_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (tick[0] === 1'b1) tick0_seen++;
      compare_all();
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; game_rst = 1'b0; halt = 1'b0; move_btn = 1'b0; level_up = 1'b0;
    speed_change = 8'd0; lane_dir = '0; lane_shift = '0;
    step_cycles(1);
    sys_rst = 1'b0;
  endtask

  function automatic int lane_pos(input int i);
    return int'(pos[i*PW +: PW]);
  endfunction

  initial begin
    // reset state
    do_reset();
    chk("rst_pos0", lane_pos(0), 0);
    chk("rst_pos1", lane_pos(1), 0);
    chk("rst_speed", int'(speed), INIT_SP);
    chk("rst_tick", int'(tick), 0);

    // 24 held cycles at period 8 -> three steps
    tick0_seen = 0;
    move_btn = 1'b1;
    step_cycles(24);
    chk("hold24_pos0", lane_pos(0), 3);
    chk("hold24_ticks0", tick0_seen, 3);

    // wrap in both directions
    do_reset();
    lane_dir = 2'b10;
    move_btn = 1'b1;
    step_cycles(8);
    chk("wrap_dn_pos1", lane_pos(1), 9);
    step_cycles(64);
    chk("lane0_at9", lane_pos(0), 9);
    step_cycles(8);
    chk("wrap_up_pos0", lane_pos(0), 0);

    // level-up with saturation
    do_reset();
    speed_change = 8'd3;
    level_up = 1'b1;
    step_cycles(1);
    chk("lvl1_speed", int'(speed), 5);
    step_cycles(1);
    chk("lvl2_speed", int'(speed), 2);
    step_cycles(1);
    chk("lvl3_speed", int'(speed), 2);
    level_up = 1'b0;

    // halt mid-count, level_up ignored while halted, then resume the same count
    do_reset();
    move_btn = 1'b1;
    step_cycles(3);
    halt = 1'b1; level_up = 1'b1; speed_change = 8'd3;
    step_cycles(20);
    chk("halt_pos0", lane_pos(0), 0);
    chk("halt_tick", int'(tick), 0);
    chk("halt_speed", int'(speed), 8);
    halt = 1'b0; level_up = 1'b0;
    step_cycles(4);
    chk("resume_pos0_early", lane_pos(0), 0);
    step_cycles(1);
    chk("resume_pos0", lane_pos(0), 1);
    chk("resume_tick0", int'(tick[0]), 1);

    // per-lane shift: period 2, then forced period 1
    do_reset();
    lane_shift = 4'b1000;
    move_btn = 1'b1;
    step_cycles(10);
    chk("shift2_pos1", lane_pos(1), 5);
    chk("shift0_pos0", lane_pos(0), 1);
    do_reset();
    speed_change = 8'd3;
    level_up = 1'b1;
    step_cycles(2);
    level_up = 1'b0;
    chk("slow_speed", int'(speed), 2);
    lane_shift = 4'b1100;
    move_btn = 1'b1;
    step_cycles(4);
    chk("per1_pos1", lane_pos(1), 4);
    chk("per1_tick1", int'(tick[1]), 1);
    chk("per2_pos0", lane_pos(0), 2);

    // game restart coinciding with a tick and a level-up
    do_reset();
    move_btn = 1'b1;
    step_cycles(7);
    game_rst = 1'b1; level_up = 1'b1; speed_change = 8'd3;
    step_cycles(1);
    chk("grst_pos0", lane_pos(0), 0);
    chk("grst_tick", int'(tick), 0);
    chk("grst_speed", int'(speed), 8);
    game_rst = 1'b0; level_up = 1'b0;
    step_cycles(8);
    chk("grst_restart_pos0", lane_pos(0), 1);

    // randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      sys_rst      = ($urandom_range(0, 149) == 0);
      game_rst     = ($urandom_range(0, 99) == 0);
      halt         = ($urandom_range(0, 7) == 0);
      move_btn     = ($urandom_range(0, 3) != 0);
      level_up     = ($urandom_range(0, 24) == 0);
      speed_change = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) lane_dir = NL'($urandom);
      if ($urandom_range(0, 19) == 0) lane_shift = (2*NL)'($urandom);
      step_cycles(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
